// File: rtl/sr_lock_pkg.sv
// ---------------------------------------------------------------------------
// sr_lock_pkg
// Shared definitions for the SR-flag lock arbiter:
//   - state_t   : arbiter FSM state encoding (IDLE, HOLD, REL)
//   - RST_*     : register values applied while rst is high
//   - onehot()  : index -> one-hot vector helper (caller truncates to N bits)
// ---------------------------------------------------------------------------
package sr_lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  // Reset values. r_out is high during reset so the external flag is
  // actively cleared rather than left in an unknown state.
  localparam state_t RST_STATE    = ST_IDLE;
  localparam logic   RST_S_OUT    = 1'b0;
  localparam logic   RST_R_OUT    = 1'b1;
  localparam logic   RST_BUSY     = 1'b0;
  localparam logic   RST_TO_PULSE = 1'b0;

  // Upper bound on requester count supported by onehot().
  localparam int MAX_N = 64;

  // Returns a vector with only bit idx set, provided idx < n.
  function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
    logic [MAX_N-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_N; i++) begin
      v[i] = (i < n) && (i == idx);
    end
    return v;
  endfunction

endpackage

// File: rtl/sr_lock_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker.
//   req   [N]  : request vector
//   ptr   [OW] : highest-priority index (must be < N)
//   valid      : at least one request is asserted
//   idx   [OW] : first asserted request scanning ptr, ptr+1, ... mod N
// The request vector is duplicated and shifted right by ptr so the winner
// is simply the lowest set bit of the low N bits; its offset is then added
// back to ptr with an explicit mod-N correction (N need not be 2^k).
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int OW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] ptr,
  output logic          valid,
  output logic [OW-1:0] idx
);
  import sr_lock_pkg::*;

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_win;
  logic [OW:0]    w_off;
  logic [OW:0]    w_sum;

  assign w_dbl = {req, req};
  assign valid = |req;

  // Rotate so ptr lands at bit 0, then priority-encode the lowest set bit.
  always_comb begin
    w_win = N'(w_dbl >> ptr);
    w_off = '0;
    // Descending scan: the last hit written is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (w_win[i]) begin
        w_off = (OW+1)'(i);
      end else begin
        w_off = w_off;
      end
    end
  end

  // Map the rotated offset back to an absolute requester index, mod N.
  always_comb begin
    w_sum = {1'b0, ptr} + w_off;
    if (w_sum >= (OW+1)'(N)) begin
      idx = OW'(w_sum - (OW+1)'(N));
    end else begin
      idx = OW'(w_sum);
    end
  end

endmodule

// File: rtl/sr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// sr_lock_arbiter
// Round-robin arbiter sharing one external SR lock flag among N requesters.
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   req   [N]      : per-requester lock request (level)
//   rel   [N]      : per-requester release pulse
//   gnt   [N]      : one-hot grant (registered)
//   busy           : lock held, equals |gnt (registered)
//   owner [OW]     : current owner index, 0 when idle (registered)
//   s_out          : one-cycle set pulse to the external flag
//   r_out          : one-cycle reset pulse to the external flag
//   timeout_pulse  : one-cycle flag, grant revoked by timeout
// s_out is only raised on IDLE->HOLD and r_out only on HOLD->REL or reset,
// so the two can never be high together.
// ---------------------------------------------------------------------------
module sr_lock_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 15,
  parameter int OW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  rel,
  output logic [N-1:0]  gnt,
  output logic          busy,
  output logic [OW-1:0] owner,
  output logic          s_out,
  output logic          r_out,
  output logic          timeout_pulse
);
  import sr_lock_pkg::*;

  // Counter is at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t        r_state;
  logic [OW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_gnt;
  logic          r_busy;
  logic [OW-1:0] r_owner;
  logic          r_s_out;
  logic          r_r_out;
  logic          r_to_pulse;

  state_t        w_state_nxt;
  logic [OW-1:0] w_ptr_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [N-1:0]  w_gnt_nxt;
  logic [OW-1:0] w_owner_nxt;
  logic          w_s_nxt;
  logic          w_r_nxt;
  logic          w_to_nxt;

  logic          w_pick_valid;
  logic [OW-1:0] w_pick_idx;
  logic [OW:0]   w_ptr_inc;
  logic          w_rel_hit;
  logic          w_to_hit;

  rr_pick #(.N(N), .OW(OW)) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  assign w_ptr_inc = {1'b0, w_pick_idx} + (OW+1)'(1);
  assign w_rel_hit = rel[r_owner] | ~req[r_owner];
  assign w_to_hit  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // Next-state and next-output logic for the lock FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_s_nxt     = 1'b0;
    w_r_nxt     = 1'b0;
    w_to_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt   = '0;
        w_owner_nxt = '0;
        w_cnt_nxt   = '0;
        // r_out high in IDLE only happens on the edge right after reset:
        // that edge finishes clearing the flag and does not arbitrate.
        if (w_pick_valid && !r_r_out) begin
          w_state_nxt = ST_HOLD;
          w_gnt_nxt   = N'(onehot(int'(w_pick_idx), N));
          w_owner_nxt = w_pick_idx;
          w_s_nxt     = 1'b1;
          if (w_ptr_inc >= (OW+1)'(N)) begin
            w_ptr_nxt = '0;
          end else begin
            w_ptr_nxt = w_ptr_inc[OW-1:0];
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (TIMEOUT != 0) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          w_cnt_nxt = '0;
        end
        if (w_rel_hit || w_to_hit) begin
          w_state_nxt = ST_REL;
          w_gnt_nxt   = '0;
          w_owner_nxt = '0;
          w_cnt_nxt   = '0;
          w_r_nxt     = 1'b1;
          // A genuine release on the same edge takes precedence.
          w_to_nxt    = w_to_hit & ~w_rel_hit;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_REL: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_owner_nxt = '0;
        w_cnt_nxt   = '0;
      end
      default: begin
        // Unreachable encoding: drop any grant and clear the flag.
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_owner_nxt = '0;
        w_cnt_nxt   = '0;
        w_r_nxt     = 1'b1;
      end
    endcase
  end

  // State, counter, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RST_STATE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_busy     <= RST_BUSY;
      r_owner    <= '0;
      r_s_out    <= RST_S_OUT;
      r_r_out    <= RST_R_OUT;
      r_to_pulse <= RST_TO_PULSE;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_busy     <= |w_gnt_nxt;
      r_owner    <= w_owner_nxt;
      r_s_out    <= w_s_nxt;
      r_r_out    <= w_r_nxt;
      r_to_pulse <= w_to_nxt;
    end
  end

  assign gnt           = r_gnt;
  assign busy          = r_busy;
  assign owner         = r_owner;
  assign s_out         = r_s_out;
  assign r_out         = r_r_out;
  assign timeout_pulse = r_to_pulse;

endmodule
